// File: rtl/pe_injection_scheduler_pkg.sv
// Shared ring packet field positions and the shortest-direction route helper
// used by the injection scheduler, switch arbiters and output controllers.
package pe_injection_scheduler_pkg;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_HI  = 55;
    localparam int HOP_LO  = 48;
    localparam int SRC_HI  = 47;
    localparam int SRC_LO  = 40;
    localparam int DST_HI  = 39;
    localparam int DST_LO  = 32;
    localparam int NODE_W  = 8;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } ring_dir_e;

    typedef struct packed {
        ring_dir_e         dir;
        logic [NODE_W-1:0] hop;
    } route_t;

    // Only meaningful for dest < num_nodes; the sum then stays below 2*num_nodes,
    // so a single conditional subtract implements the modulo.
    function automatic route_t compute_route(input logic [NODE_W-1:0] dest,
                                             input logic [8:0] num_nodes,
                                             input logic [8:0] node_id);
        logic [8:0] sum;
        logic [8:0] cw_dist;
        logic [8:0] ccw_dist;
        route_t     r;
        sum      = {1'b0, dest} + num_nodes - node_id;
        cw_dist  = (sum >= num_nodes) ? sum - num_nodes : sum;
        ccw_dist = num_nodes - cw_dist;
        if (cw_dist <= ccw_dist) begin
            r.dir = DIR_CW;
            r.hop = NODE_W'(cw_dist);
        end else begin
            r.dir = DIR_CCW;
            r.hop = NODE_W'(ccw_dist);
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_injection_scheduler_if.sv
// PE request and router PE-input bundle of the injection scheduler, plus its
// status counters; slave is the scheduler, master is the PE/router side.
interface pe_injection_scheduler_if #(
    parameter int DEPTH = 4
);
    logic                       pe_req_valid;
    logic                       pe_req_ready;
    logic [7:0]                 pe_req_dest;
    logic [31:0]                pe_req_payload;
    logic                       polarity;
    logic                       rtr_valid;
    logic                       rtr_ready;
    logic [63:0]                rtr_data;
    logic [$clog2(DEPTH):0]     fifo_level;
    logic [15:0]                tx_count;
    logic [7:0]                 drop_count;

    modport slave (
        input  pe_req_valid, pe_req_dest, pe_req_payload, polarity, rtr_ready,
        output pe_req_ready, rtr_valid, rtr_data, fifo_level, tx_count, drop_count
    );

    modport master (
        output pe_req_valid, pe_req_dest, pe_req_payload, polarity, rtr_ready,
        input  pe_req_ready, rtr_valid, rtr_data, fifo_level, tx_count, drop_count
    );
endinterface

// File: rtl/pe_injection_scheduler_packet_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty; storage is not
// reset, only the pointers, so a reset empties it immediately.
module packet_fifo #(
    parameter int WIDTH = 63,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        level = wr_ptr - rd_ptr;
        dout  = mem[rd_ptr[AW-1:0]];
    end
endmodule

// File: rtl/pe_injection_scheduler.sv
// Turns PE send requests into ring packets with shortest-path DIR/HOP, queues
// them, and hands them to the router with the VC bit taken live from polarity.
module pe_injection_scheduler
    import pe_injection_scheduler_pkg::*;
#(
    parameter int NODE_ID   = 0,
    parameter int NUM_NODES = 4,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    pe_injection_scheduler_if.slave bus
);
    localparam int                LW   = $clog2(DEPTH) + 1;
    localparam logic [8:0]        N9   = 9'(NUM_NODES);
    localparam logic [8:0]        ID9  = 9'(NODE_ID);
    localparam logic [NODE_W-1:0] SRC  = NODE_W'(NODE_ID);

    route_t        route;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    // VC is never stored: it is re-stamped from polarity on the way out.
    logic [62:0]   entry;
    logic [62:0]   head;

    always_comb begin
        route  = compute_route(bus.pe_req_dest, N9, ID9);
        legal  = ({1'b0, bus.pe_req_dest} < N9) && ({1'b0, bus.pe_req_dest} != ID9);
        accept = bus.pe_req_valid && !full;
        push   = accept && legal;
        pop    = !empty && bus.rtr_ready;
        entry  = {route.dir, 6'b0, route.hop, SRC, bus.pe_req_dest, bus.pe_req_payload};
    end

    packet_fifo #(
        .WIDTH (63),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        bus.pe_req_ready = !full;
        bus.rtr_valid    = !empty;
        bus.rtr_data     = empty ? 64'h0 : {bus.polarity, head};
        bus.fifo_level   = level;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tx_count   <= '0;
            bus.drop_count <= '0;
        end else begin
            if (pop) bus.tx_count <= bus.tx_count + 16'd1;
            if (accept && !legal && bus.drop_count != 8'hFF)
                bus.drop_count <= bus.drop_count + 8'd1;
        end
    end
endmodule
